// File: rtl/io_intr_ctrl.sv
// Memory-mapped I/O block: RAM window, PEND/MASK/MODE/STATUS registers and an
// interrupt controller that arbitrates latched device requests toward the CPU.
module io_intr_ctrl #(
  parameter  int ADDR_W = 10,
  parameter  int DATA_W = 32,
  parameter  int NCH    = 4,
  localparam int DEPTH  = 2 ** ADDR_W,
  localparam int NUM_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              Clk,
  input  logic              Rst_,
  input  logic [ADDR_W-1:0] Addr,
  inout  wire  [DATA_W-1:0] Data,
  input  logic              CS_,
  input  logic              RD_,
  input  logic              WR_,
  input  logic              Enable,
  input  logic [NCH-1:0]    irq_in,
  input  logic              int_ack,
  output logic              intr,
  output logic              fintr,
  output logic [NUM_W-1:0]  intr_num
);

  localparam logic [ADDR_W-1:0] A_PEND = ADDR_W'(DEPTH - 4);
  localparam logic [ADDR_W-1:0] A_MASK = ADDR_W'(DEPTH - 3);
  localparam logic [ADDR_W-1:0] A_MODE = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(DEPTH - 1);

  // Handshake: a request (intr or fintr) stays high until int_ack is sampled
  // high; the controller then waits for int_ack sampled low before it may
  // raise the next request.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NCH-1:0]    pend, mask, mode;
  logic [NCH-1:0]    irq_r, irq_d, rise, elig, w1c, ack_clr;
  logic [NUM_W-1:0]  num, win;
  logic              fast, win_fast, latch;
  logic              bus_rd, bus_wr, is_ram;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [DEPTH];

  // Bus decode
  assign bus_rd = Enable & ~CS_ & ~RD_;
  assign bus_wr = Enable & ~CS_ & ~WR_;
  assign is_ram = (Addr < A_PEND);
  assign Data   = bus_rd ? rd_word : 'z;

  assign rise    = irq_r & ~irq_d;
  assign elig    = pend & ~mask;
  assign w1c     = (bus_wr && (Addr == A_PEND)) ? Data[NCH-1:0] : '0;
  assign ack_clr = ((state == S_ASSERT) && int_ack) ? (NCH'(1) << num) : '0;

  assign intr_num = num;

  // Lowest eligible channel, overridden by the lowest eligible fast channel.
  always_comb begin
    win      = '0;
    win_fast = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i]) win = NUM_W'(i);
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (elig[i] && mode[i]) begin
        win      = NUM_W'(i);
        win_fast = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    intr      = 1'b0;
    fintr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (elig != '0) begin
          latch     = 1'b1;
          state_nxt = S_ASSERT;
        end
      end
      S_ASSERT: begin
        intr  = ~fast;
        fintr = fast;
        if (int_ack) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!int_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_) begin
    if (!Rst_) begin
      state <= S_IDLE;
      num   <= '0;
      fast  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        num  <= win;
        fast <= win_fast;
      end
    end
  end

  // A hardware set wins over both software W1C and the ack clear.
  always_ff @(posedge Clk or negedge Rst_) begin
    if (!Rst_) begin
      pend  <= '0;
      mask  <= '1;
      mode  <= '0;
      irq_r <= '0;
      irq_d <= '0;
    end else begin
      irq_r <= irq_in;
      irq_d <= irq_r;
      pend  <= (pend & ~(w1c | ack_clr)) | rise;
      if (bus_wr && (Addr == A_MASK)) mask <= Data[NCH-1:0];
      if (bus_wr && (Addr == A_MODE)) mode <= Data[NCH-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (bus_wr && is_ram) mem[Addr] <= Data;
  end

  always_comb begin
    rd_word = '0;
    case (Addr)
      A_PEND: rd_word[NCH-1:0] = pend;
      A_MASK: rd_word[NCH-1:0] = mask;
      A_MODE: rd_word[NCH-1:0] = mode;
      A_STAT: begin
        rd_word[0]       = (state != S_IDLE);
        rd_word[NUM_W:1] = num;
      end
      default: rd_word = mem[Addr];
    endcase
  end

endmodule
